// File: rtl/gate_bist_ctrl.sv
// LFSR/MISR self-test sequencer for combinational gate models.
// One start/done handshake applies N pseudo-random patterns and checks the compacted signature.
//
// state   | meaning
// IDLE    | waiting for start; dut_in holds the last pattern
// LOAD    | seed the LFSR and arm the settle timer
// APPLY   | pattern held on dut_in while the settle timer counts down
// CAPTURE | fold dut_out into the MISR and step the LFSR
// FINISH  | one-cycle done pulse; pass is resolved
module gate_bist_ctrl #(
  parameter int             IN_W     = 14,
  parameter int             OUT_W    = 10,
  parameter int             CNT_W    = 16,
  parameter int             SETTLE   = 1,
  parameter logic [IN_W-1:0]  IN_POLY  = 14'h002B,
  parameter logic [OUT_W-1:0] OUT_POLY = 10'h081
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] expected_sig,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] pattern_cnt
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, CAPTURE, FINISH} state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  lfsr, lfsr_nxt, seed_q;
  logic [OUT_W-1:0] misr, misr_nxt, exp_q;
  logic [CNT_W-1:0] cnt, cnt_inc, num_q;
  logic [SW-1:0]    settle_cnt;
  logic             pass_q;
  logic             accept, settle_tc, last_pat;

  assign accept    = (state == IDLE) && start;
  assign settle_tc = (settle_cnt == '0);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_pat  = (cnt_inc == num_q);

  assign lfsr_nxt = {lfsr[IN_W-2:0], 1'b0} ^ (lfsr[IN_W-1] ? IN_POLY : '0);
  assign misr_nxt = {misr[OUT_W-2:0], 1'b0} ^ (misr[OUT_W-1] ? OUT_POLY : '0) ^ dut_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)               state_nxt = IDLE;
        else if (num_q == '0)    state_nxt = FINISH;
        else                     state_nxt = APPLY;
      end
      APPLY: begin
        if (abort)               state_nxt = IDLE;
        else if (settle_tc)      state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (abort)               state_nxt = IDLE;
        else if (last_pat)       state_nxt = FINISH;
        else                     state_nxt = APPLY;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FINISH);
  end

  // Run parameters are captured at accept so the inputs may change during the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= '0;
      misr       <= '0;
      cnt        <= '0;
      num_q      <= '0;
      seed_q     <= '0;
      exp_q      <= '0;
      settle_cnt <= '0;
      pass_q     <= 1'b0;
    end else begin
      if (accept) begin
        seed_q <= seed;
        num_q  <= num_patterns;
        exp_q  <= expected_sig;
        misr   <= '0;
        cnt    <= '0;
        pass_q <= 1'b0;
      end
      case (state)
        LOAD: begin
          if (abort) begin
            pass_q <= 1'b0;
          end else begin
            lfsr       <= (seed_q == '0) ? '1 : seed_q;
            settle_cnt <= SW'(SETTLE - 1);
          end
        end
        APPLY: begin
          if (abort)           pass_q     <= 1'b0;
          else if (!settle_tc) settle_cnt <= settle_cnt - SW'(1);
        end
        CAPTURE: begin
          if (abort) begin
            pass_q <= 1'b0;
          end else begin
            misr       <= misr_nxt;
            lfsr       <= lfsr_nxt;
            cnt        <= cnt_inc;
            settle_cnt <= SW'(SETTLE - 1);
          end
        end
        FINISH:  pass_q <= (misr == exp_q);
        default: ;
      endcase
    end
  end

  assign dut_in      = lfsr;
  assign signature   = misr;
  assign pattern_cnt = cnt;
  assign pass        = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: identity gate model on two instances (SETTLE=1 and SETTLE=3).
module tb_gate_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start1, start3, abort;
  logic [15:0] num;
  logic [13:0] seed;
  logic [9:0]  exp_sig;

  logic [13:0] din1, din3;
  logic [9:0]  sig1, sig3;
  logic [15:0] cnt1, cnt3;
  logic        busy1, done1, pass1, busy3, done3, pass3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .num_patterns(num), .seed(seed), .expected_sig(exp_sig),
    .dut_in(din1), .dut_out(din1[9:0]),
    .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .pattern_cnt(cnt1)
  );

  gate_bist_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
    .num_patterns(num), .seed(seed), .expected_sig(exp_sig),
    .dut_in(din3), .dut_out(din3[9:0]),
    .busy(busy3), .done(done3), .pass(pass3),
    .signature(sig3), .pattern_cnt(cnt3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference signature from the LFSR/MISR equations with an identity gate model.
  function automatic logic [9:0] model_sig(input logic [13:0] sd, input int n);
    logic [13:0] l;
    logic [9:0]  m;
    l = (sd == '0) ? 14'h3FFF : sd;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m = {m[8:0], 1'b0} ^ (m[9] ? 10'h081 : 10'h000) ^ l[9:0];
      l = {l[12:0], 1'b0} ^ (l[13] ? 14'h002B : 14'h0000);
    end
    return m;
  endfunction

  // Cycle 1 is LOAD (the period after the accepting edge); c_done is the cycle with done high.
  task automatic run(input bit s3, input logic [15:0] n, input logic [13:0] sd,
                     input logic [9:0] ex, input int pulse_at,
                     output int c_done, output logic [13:0] p2, output logic [13:0] p4,
                     output logic pass_c1);
    num = n; seed = sd; exp_sig = ex;
    if (s3) start3 = 1'b1; else start1 = 1'b1;
    tick;
    start1 = 1'b0; start3 = 1'b0;
    pass_c1 = s3 ? pass3 : pass1;
    p2 = '0; p4 = '0; c_done = -1;
    for (int c = 2; c <= 600 && c_done < 0; c++) begin
      if (c == pulse_at) start3 = 1'b1;
      tick;
      start3 = 1'b0;
      if (c == 2) p2 = s3 ? din3 : din1;
      if (c == 4) p4 = s3 ? din3 : din1;
      if (s3 ? done3 : done1) c_done = c;
    end
    tick;
    chk("done_one_cycle", {31'b0, s3 ? done3 : done1}, 32'd0);
    chk("busy_falls",     {31'b0, s3 ? busy3 : busy1}, 32'd0);
  endtask

  int          cd;
  logic [13:0] p2, p4;
  logic        pc1, seen_done;
  logic [9:0]  m100;

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; abort = 1'b0;
    num = '0; seed = '0; exp_sig = '0;
    #2;
    chk("rst_busy", {31'b0, busy1}, 0);
    chk("rst_done", {31'b0, done1}, 0);
    chk("rst_pass", {31'b0, pass1}, 0);
    chk("rst_din",  {18'b0, din1}, 0);
    chk("rst_sig",  {22'b0, sig1}, 0);
    chk("rst_cnt",  {16'b0, cnt1}, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // seed=1, N=1
    run(1'b0, 16'd1, 14'h0001, 10'h001, 0, cd, p2, p4, pc1);
    chk("n1_done_cycle", cd, 4);
    chk("n1_pattern0",   {18'b0, p2}, 32'h0001);
    chk("n1_sig",        {22'b0, sig1}, 32'h001);
    chk("n1_cnt",        {16'b0, cnt1}, 1);
    chk("n1_pass",       {31'b0, pass1}, 1);
    chk("idle_din_hold", {18'b0, din1}, 32'h0002);
    tick;

    // seed=1, N=2, signature folds back to zero
    run(1'b0, 16'd2, 14'h0001, 10'h000, 0, cd, p2, p4, pc1);
    chk("n2_done_cycle", cd, 6);
    chk("n2_pattern1",   {18'b0, p4}, 32'h0002);
    chk("n2_sig",        {22'b0, sig1}, 32'h000);
    chk("n2_cnt",        {16'b0, cnt1}, 2);
    chk("n2_pass",       {31'b0, pass1}, 1);
    tick;

    // zero seed replaced by all-ones
    run(1'b0, 16'd1, 14'h0000, 10'h3FF, 0, cd, p2, p4, pc1);
    chk("s0_pattern0", {18'b0, p2}, 32'h3FFF);
    chk("s0_sig",      {22'b0, sig1}, 32'h3FF);
    chk("s0_pass",     {31'b0, pass1}, 1);
    tick;

    run(1'b0, 16'd1, 14'h0000, 10'h3FE, 0, cd, p2, p4, pc1);
    chk("bad_pass_cleared_on_accept", {31'b0, pc1}, 0);
    chk("bad_done_cycle", cd, 4);
    chk("bad_sig",        {22'b0, sig1}, 32'h3FF);
    chk("bad_pass",       {31'b0, pass1}, 0);
    tick;

    // N=0
    run(1'b0, 16'd0, 14'h0001, 10'h000, 0, cd, p2, p4, pc1);
    chk("n0_done_cycle", cd, 2);
    chk("n0_sig",        {22'b0, sig1}, 0);
    chk("n0_cnt",        {16'b0, cnt1}, 0);
    chk("n0_pass",       {31'b0, pass1}, 1);
    tick;
    run(1'b0, 16'd0, 14'h0001, 10'h005, 0, cd, p2, p4, pc1);
    chk("n0_pass_nonzero_exp", {31'b0, pass1}, 0);
    tick;

    // SETTLE=3, N=100, stray start pulse mid-run
    m100 = model_sig(14'h0001, 100);
    run(1'b1, 16'd100, 14'h0001, m100, 50, cd, p2, p4, pc1);
    chk("n100_done_cycle", cd, 402);
    chk("n100_cnt",        {16'b0, cnt3}, 100);
    chk("n100_sig",        {22'b0, sig3}, {22'b0, m100});
    chk("n100_pass",       {31'b0, pass3}, 1);
    tick;

    // abort in the 5th APPLY cycle (cycle 7 after accept)
    num = 16'd100; seed = 14'h0001; exp_sig = 10'h000;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    repeat (6) tick;
    chk("abort_pre_busy", {31'b0, busy3}, 1);
    chk("abort_pre_cnt",  {16'b0, cnt3}, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy3}, 0);
    chk("abort_pass", {31'b0, pass3}, 0);
    chk("abort_cnt",  {16'b0, cnt3}, 1);
    chk("abort_sig",  {22'b0, sig3}, 32'h001);
    chk("abort_din",  {18'b0, din3}, 32'h0002);
    seen_done = done3;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen_done = seen_done | done3;
    end
    chk("abort_no_done", {31'b0, seen_done}, 0);

    // asynchronous reset mid-run
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    repeat (10) tick;
    chk("prerst_busy", {31'b0, busy3}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy3}, 0);
    chk("arst_done", {31'b0, done3}, 0);
    chk("arst_pass", {31'b0, pass3}, 0);
    chk("arst_din",  {18'b0, din3}, 0);
    chk("arst_sig",  {22'b0, sig3}, 0);
    chk("arst_cnt",  {16'b0, cnt3}, 0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Parametrised built-in self-test sequencer for the combinational gate models in the simulator's gate library. It drives pseudo-random patterns from an LFSR into a gate model of configurable input and output width. After a configurable settle time, it compacts the model's outputs into a MISR signature. At the end of the run it reports pass/fail against an expected signature, so any library netlist can be regression-checked with a single start/done handshake.

## Interface
- `IN_W`, 14, LFSR width; equals the model input count.
- `OUT_W`, 10, MISR width; equals the model output count.
- `CNT_W`, 16, pattern counter width.
- `SETTLE`, 1, cycles each pattern is held before capture; must be ≥1.
- `IN_POLY`, 14'h002B, Galois LFSR feedback mask (x^14+x^5+x^3+x+1).
- `OUT_POLY`, 10'h081, Galois MISR feedback mask (x^10+x^7+1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `abort`  in  1  cancels a running test.
- `num_patterns`  in  CNT_W  number of patterns to apply; sampled on accept.
- `seed`  in  IN_W  LFSR seed; sampled on accept.
- `expected_sig`  in  OUT_W  reference signature; sampled on accept.
- `dut_in`  out  IN_W  pattern driven to the gate model; equals the LFSR register.
- `dut_out`  in  OUT_W  gate-model outputs.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in FINISH.
- `pass`  out  1  result of the last completed run; holds until the next accept or abort.
- `signature`  out  OUT_W  MISR register contents.
- `pattern_cnt`  out  CNT_W  patterns captured so far.

## Operation
- States: IDLE, LOAD, APPLY, CAPTURE, FINISH.
- Reset (asynchronous):
  - State is IDLE.
  - LFSR, MISR and all counters are 0.
  - `busy`, `done` and `pass` are 0.
- IDLE:
  - `start`=1 moves to LOAD.
  - In LOAD, the LFSR loads `seed`; a zero seed is replaced by all-ones to avoid lock-up.
  - LOAD also clears the MISR and `pattern_cnt`, clears `pass`, and latches `num_patterns` and `expected_sig`.
- LOAD → APPLY. If the latched `num_patterns`==0, LOAD → FINISH instead.
- APPLY:
  - `dut_in` is held steady.
  - The settle counter runs for SETTLE cycles, then the state moves to CAPTURE.
- CAPTURE:
  - MISR update: misr ← {misr[OUT_W-2:0],0} ^ (misr[OUT_W-1] ? OUT_POLY : 0) ^ `dut_out`.
  - LFSR update: lfsr ← {lfsr[IN_W-2:0],0} ^ (lfsr[IN_W-1] ? IN_POLY : 0).
  - `pattern_cnt` increments.
  - If the new count equals `num_patterns`, go to FINISH; otherwise return to APPLY.
- FINISH:
  - `done`=1 for exactly one cycle.
  - `pass` ← (MISR == latched expected).
  - Next state is IDLE.
- `abort`=1 in LOAD, APPLY or CAPTURE:
  - The next state is IDLE and no `done` pulse is produced.
  - `pass` is forced to 0; `signature` and `pattern_cnt` hold their partial values.
  - `abort` in IDLE or FINISH is ignored, and FINISH completes normally.
- Simultaneous `start` and `abort` in IDLE: `start` wins.
- `start` while `busy`=1 is ignored; `start` during FINISH is ignored.
- The counter wraps only through `num_patterns`. The maximum run is 2^CNT_W−1 patterns.
- In IDLE, `dut_in` holds its last value.

## Timing
- Let `start` be sampled at edge k:
  - LOAD occupies cycle k+1.
  - Pattern i (i = 0..N−1) occupies APPLY for SETTLE cycles, then one CAPTURE cycle.
  - `done` is high in cycle k+2+N·(SETTLE+1); `busy` falls in the following cycle.
- `dut_out` is sampled at the CAPTURE clock edge, which is SETTLE+1 edges after the pattern appeared on `dut_in`.
- `pass` and `signature` are valid from the `done` cycle onward.
- When N=0, `done` is high at cycle k+2 and `signature`=0.
- A reset assertion mid-run returns to the reset values immediately, without waiting for a clock.

## Test plan
- Identity DUT (`dut_out`=`dut_in[9:0]`), `seed`=1, N=1, SETTLE=1, start at edge k:
  - `done` in cycle k+4.
  - `signature`=10'h001, `pattern_cnt`=1.
- Same DUT, `seed`=1, N=2, `expected_sig`=10'h000:
  - The second pattern is 14'h0002.
  - `signature`=10'h000, `pass`=1, `done` at k+6.
- `seed`=0, N=1, identity DUT, `expected_sig`=10'h3FF:
  - The LFSR loads 14'h3FFF.
  - `signature`=10'h3FF, `pass`=1.
- Repeat the previous case with `expected_sig`=10'h3FE → `pass`=0 and `done` still pulses.
- N=0 → `done` at k+2, `signature`=0, `pass`=(`expected_sig`==0).
- Abort tests, with N=100 and SETTLE=3:
  - Assert `abort` in the 5th APPLY cycle → IDLE next cycle, no `done`, `pass`=0, `busy`=0.
  - Assert `rst_n`=0 mid-run → all outputs 0 asynchronously.
  - Pulse `start` while busy → the run is unaffected.
